icache_axi_read_bridge: RTL and testbench

AXI4 read master that serves the instruction cache's miss/uncached read port. It accepts one request at a time from I-cache stage 2, issues a single AR transaction, and collects the R beats into a 512-bit line. It returns that line with a one-cycle `ReadBackAble` pulse. It sits between I-cache stage 2 and the core's AXI interconnect and owns the `CacReadfree`/`IRshankhand`/`ReadBackAble` handshake that stage 2's MSHR FIFO depends on.

---
 rtl/icache_axi_read_bridge.sv | 145 ++++++++++++++
 tb/tb_icache_axi_read_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_read_bridge.sv
// AXI4 read master for the I-cache miss/uncached port: one AR per request,
// R beats gathered into a line and returned with a single ReadBackAble pulse.
module icache_axi_read_bridge #(
  parameter logic [3:0] ARID_VALUE = 4'd0,
  parameter int         LINE_BEATS = 16
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic                     ICacheFlash,
  input  logic                     IcaReadAble,
  input  logic                     IUncacheRead,
  input  logic [31:0]              IcaReadAddr,
  output logic                     CacReadfree,
  output logic                     IRshankhand,
  output logic                     ReadBackAble,
  output logic [LINE_BEATS*32-1:0] ReadBackDate,
  output logic                     ReadErr,
  output logic [3:0]               ArId,
  output logic [31:0]              ArAddr,
  output logic [7:0]               ArLen,
  output logic [2:0]               ArSize,
  output logic [1:0]               ArBurst,
  output logic                     ArValid,
  input  logic                     ArReady,
  input  logic [3:0]               RId,
  input  logic [31:0]              RData,
  input  logic [1:0]               RResp,
  input  logic                     RLast,
  input  logic                     RValid,
  output logic                     RReady
);

  localparam int              CW         = $clog2(LINE_BEATS + 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(LINE_BEATS);
  localparam logic [7:0]      CACHED_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateType;

  stateType      stateReg, stateNext;
  logic          cachedReg;
  logic [31:0]   arAddrReg;
  logic [7:0]    arLenReg;
  logic [CW-1:0] cntReg;
  logic [CW-1:0] cntInc;
  logic [CW-1:0] expCnt;
  logic          errReg;
  logic          dropReg;
  logic          handshakeReg;
  logic          accept;
  logic          beat;
  logic          beatErr;
  logic          unusedBits;

  // Only one transaction is ever outstanding, so RId carries no information.
  assign unusedBits = ^{RId, IcaReadAddr[1:0]};

  always_comb begin
    stateNext    = stateReg;
    CacReadfree  = 1'b0;
    ArValid      = 1'b0;
    RReady       = 1'b0;
    ReadBackAble = 1'b0;
    accept       = 1'b0;
    beat         = 1'b0;
    case (stateReg)
      IDLE: begin
        CacReadfree = ~ICacheFlash;
        accept      = ~ICacheFlash & (IcaReadAble | IUncacheRead);
        if (accept) stateNext = ADDR;
      end
      ADDR: begin
        ArValid = 1'b1;
        if (ArReady) stateNext = DATA;
      end
      DATA: begin
        RReady = 1'b1;
        beat   = RValid;
        if (RValid && RLast) stateNext = DATA == DATA ? DONE : DATA;
      end
      DONE: begin
        ReadBackAble = ~dropReg & ~ICacheFlash;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Error on a bad response, on any beat past the expected count, or on an
  // RLast that closes the burst at the wrong length.
  always_comb begin
    expCnt  = cachedReg ? FULL_CNT : CW'(1);
    cntInc  = (cntReg == FULL_CNT) ? cntReg : cntReg + CW'(1);
    beatErr = (RResp != 2'b00) | (cntReg >= expCnt) |
              (RLast & ((cntReg + CW'(1)) != expCnt));
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      stateReg     <= IDLE;
      cachedReg    <= 1'b0;
      arAddrReg    <= '0;
      arLenReg     <= '0;
      cntReg       <= '0;
      errReg       <= 1'b0;
      dropReg      <= 1'b0;
      handshakeReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      handshakeReg <= accept;
      if (accept) begin
        cachedReg <= IcaReadAble;
        arAddrReg <= IcaReadAble ? {IcaReadAddr[31:6], 6'b0} : {IcaReadAddr[31:2], 2'b0};
        arLenReg  <= IcaReadAble ? CACHED_LEN : 8'd0;
        cntReg    <= '0;
        errReg    <= 1'b0;
        dropReg   <= 1'b0;
      end else begin
        if ((stateReg == ADDR || stateReg == DATA) && ICacheFlash) dropReg <= 1'b1;
        if (beat) begin
          cntReg <= cntInc;
          if (beatErr) errReg <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : gSlot
    logic [31:0] slotReg;
    always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) slotReg <= '0;
      else if (accept) slotReg <= '0;
      else if (beat && cntReg == CW'(gi)) slotReg <= RData;
    end
    assign ReadBackDate[gi*32 +: 32] = slotReg;
  end

  assign IRshankhand = handshakeReg;
  assign ReadErr     = ReadBackAble & errReg;
  assign ArId        = ARID_VALUE;
  assign ArAddr      = arAddrReg;
  assign ArLen       = arLenReg;
  assign ArSize      = 3'b010;
  assign ArBurst     = 2'b01;

endmodule

// File: tb/tb_icache_axi_read_bridge.sv
// Bench for icache_axi_read_bridge: an AXI slave driver plus a scoreboard of
// expected lines popped on every ReadBackAble pulse.
module tb_icache_axi_read_bridge;

  logic         Clk, Rest, ICacheFlash, IcaReadAble, IUncacheRead;
  logic [31:0]  IcaReadAddr;
  logic         CacReadfree, IRshankhand, ReadBackAble, ReadErr;
  logic [511:0] ReadBackDate;
  logic [3:0]   ArId;
  logic [31:0]  ArAddr;
  logic [7:0]   ArLen;
  logic [2:0]   ArSize;
  logic [1:0]   ArBurst;
  logic         ArValid, ArReady;
  logic [3:0]   RId;
  logic [31:0]  RData;
  logic [1:0]   RResp;
  logic         RLast, RValid, RReady;

  icache_axi_read_bridge dut (
    .Clk(Clk), .Rest(Rest), .ICacheFlash(ICacheFlash), .IcaReadAble(IcaReadAble),
    .IUncacheRead(IUncacheRead), .IcaReadAddr(IcaReadAddr), .CacReadfree(CacReadfree),
    .IRshankhand(IRshankhand), .ReadBackAble(ReadBackAble), .ReadBackDate(ReadBackDate),
    .ReadErr(ReadErr), .ArId(ArId), .ArAddr(ArAddr), .ArLen(ArLen), .ArSize(ArSize),
    .ArBurst(ArBurst), .ArValid(ArValid), .ArReady(ArReady), .RId(RId), .RData(RData),
    .RResp(RResp), .RLast(RLast), .RValid(RValid), .RReady(RReady)
  );

  typedef struct packed {
    logic [511:0] line;
    logic         err;
  } expType;

  expType sbQ[$];
  expType monExp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irCyc, rbaCyc, rbaCount, acceptCyc, freeCyc, lastBeatCyc, beatsAccepted;
  logic [31:0] arAddrSeen;
  logic [7:0]  arLenSeen;
  logic [2:0]  arSizeSeen;
  logic [1:0]  arBurstSeen;
  logic [3:0]  arIdSeen;
  bit          arStable;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Scoreboard monitor: every pulse must match the oldest pushed expectation.
  always @(negedge Clk) begin
    if (IRshankhand) irCyc = cyc;
    if (ReadBackAble) begin
      rbaCount++;
      rbaCyc = cyc;
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: ReadBackAble=1 at cycle %0d, required 0", cyc);
      end else begin
        monExp = sbQ.pop_front();
        if (ReadBackDate !== monExp.line) begin
          errors++;
          $display("FAIL line_data: got %h required %h", ReadBackDate, monExp.line);
        end
        checks++;
        if (ReadErr !== monExp.err) begin
          errors++;
          $display("FAIL read_err: got %b required %b", ReadErr, monExp.err);
        end
      end
    end
  end

  function automatic logic [511:0] build_line(input int n, input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16 && i < n; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic push_exp(input int n, input logic [31:0] base, input logic err);
    expType e;
    e.line = build_line(n, base);
    e.err  = err;
    sbQ.push_back(e);
  endtask

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d, required DUT response", what, cyc);
  endtask

  // mode: 1 cached, 2 uncached, 3 both. Negative beat indices disable a feature.
  task automatic run_txn(input logic [31:0] addr, input int mode, input int arStall,
                         input int nBeats, input int bubble, input int errBeat,
                         input int flushBeat, input int resetBeat, input logic [31:0] base);
    bit ok;
    int n;
    arStable = 1; beatsAccepted = 0; freeCyc = -1; acceptCyc = -1;
    irCyc = -1; rbaCyc = -1; lastBeatCyc = -1;
    @(posedge Clk); #1;
    IcaReadAble = (mode != 2); IUncacheRead = (mode != 1); IcaReadAddr = addr;
    ArReady = (arStall == 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (CacReadfree) begin ok = 1; acceptCyc = cyc; end
      @(posedge Clk); #1;
    end
    IcaReadAble = 0; IUncacheRead = 0; IcaReadAddr = $urandom;
    if (!ok) begin timeout_fail("accept_wait"); return; end
    ok = 0; n = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        arAddrSeen = ArAddr; arLenSeen = ArLen; arSizeSeen = ArSize;
        arBurstSeen = ArBurst; arIdSeen = ArId;
      end else if (ArAddr !== arAddrSeen || ArLen !== arLenSeen) arStable = 0;
      if (ArValid !== 1'b1) arStable = 0;
      if (ArValid && ArReady) ok = 1; else n++;
      @(posedge Clk); #1;
      if (n >= arStall) ArReady = 1;
    end
    ArReady = 0;
    if (!ok) begin timeout_fail("ar_handshake"); return; end
    for (int b = 0; b < nBeats; b++) begin
      if (bubble != 0 && b > 0) begin
        RValid = 0; RLast = 0;
        @(posedge Clk); #1;
      end
      RValid = 1; RData = base + 32'(b); RResp = (b == errBeat) ? 2'b10 : 2'b00;
      RLast = (b == nBeats - 1); ICacheFlash = (b == flushBeat); RId = 4'($urandom);
      if (b == resetBeat) begin
        Rest = 0; RValid = 0; RLast = 0; ICacheFlash = 0;
        return;
      end
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge Clk);
        if (RReady) begin ok = 1; beatsAccepted++; lastBeatCyc = cyc; end
        @(posedge Clk); #1;
        ICacheFlash = 0;
      end
      if (!ok) begin RValid = 0; RLast = 0; timeout_fail("r_beat"); return; end
    end
    RValid = 0; RLast = 0; RResp = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clk);
      if (CacReadfree) begin ok = 1; freeCyc = cyc; end
      @(posedge Clk); #1;
    end
    if (!ok) timeout_fail("free_wait");
  endtask

  task automatic test_reset;
    Rest = 0; ICacheFlash = 0; IcaReadAble = 0; IUncacheRead = 0; IcaReadAddr = 0;
    ArReady = 0; RId = 0; RData = 0; RResp = 0; RLast = 0; RValid = 0;
    repeat (3) @(posedge Clk);
    #1 Rest = 1;
    @(negedge Clk);
    checks++; if (CacReadfree !== 1'b1) begin errors++; $display("FAIL rst_free: got %b required 1", CacReadfree); end
    checks++; if (IRshankhand !== 1'b0) begin errors++; $display("FAIL rst_hs: got %b required 0", IRshankhand); end
    checks++; if (ReadBackAble !== 1'b0 || ReadErr !== 1'b0) begin errors++; $display("FAIL rst_rba: got %b/%b required 0/0", ReadBackAble, ReadErr); end
    checks++; if (ArValid !== 1'b0 || RReady !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b/%b required 0/0", ArValid, RReady); end
    checks++; if (ArAddr !== 32'h0 || ArLen !== 8'h0) begin errors++; $display("FAIL rst_ar: got %h/%h required 0/0", ArAddr, ArLen); end
    checks++; if (ReadBackDate !== 512'h0) begin errors++; $display("FAIL rst_data: got %h required 0", ReadBackDate); end
    @(posedge Clk); #1;
    ICacheFlash = 1; IcaReadAble = 1;
    @(negedge Clk);
    checks++; if (CacReadfree !== 1'b0) begin errors++; $display("FAIL flush_idle_free: got %b required 0", CacReadfree); end
    @(posedge Clk); #1;
    ICacheFlash = 0; IcaReadAble = 0;
    @(negedge Clk);
    checks++; if (IRshankhand !== 1'b0 || ArValid !== 1'b0) begin errors++; $display("FAIL flush_idle_block: hs=%b arvalid=%b required 0/0", IRshankhand, ArValid); end
  endtask

  task automatic test_cached;
    int c0;
    c0 = rbaCount;
    push_exp(16, 32'hA000_0000, 1'b0);
    run_txn(32'h1C00_0044, 1, 0, 16, 0, -1, -1, -1, 32'hA000_0000);
    checks++; if (arAddrSeen !== 32'h1C00_0040) begin errors++; $display("FAIL cached_araddr: got %h required 1c000040", arAddrSeen); end
    checks++; if (arLenSeen !== 8'd15) begin errors++; $display("FAIL cached_arlen: got %0d required 15", arLenSeen); end
    checks++; if (arSizeSeen !== 3'b010 || arBurstSeen !== 2'b01 || arIdSeen !== 4'd0) begin errors++; $display("FAIL cached_arctl: size=%b burst=%b id=%h required 010/01/0", arSizeSeen, arBurstSeen, arIdSeen); end
    checks++; if (irCyc !== acceptCyc + 1) begin errors++; $display("FAIL cached_hs_time: got %0d required %0d", irCyc, acceptCyc + 1); end
    checks++; if (rbaCyc !== acceptCyc + 18) begin errors++; $display("FAIL cached_rba_time: got %0d required %0d", rbaCyc, acceptCyc + 18); end
    checks++; if (freeCyc !== acceptCyc + 19) begin errors++; $display("FAIL cached_free_time: got %0d required %0d", freeCyc, acceptCyc + 19); end
    checks++; if (rbaCount - c0 !== 1) begin errors++; $display("FAIL cached_pulses: got %0d required 1", rbaCount - c0); end
    checks++; if (ReadBackDate !== build_line(16, 32'hA000_0000)) begin errors++; $display("FAIL cached_hold: got %h required line", ReadBackDate); end
  endtask

  task automatic test_uncached;
    expType e;
    int c0;
    c0 = rbaCount;
    e.line = '0; e.line[31:0] = 32'hDEAD_BEEF; e.err = 1'b0;
    sbQ.push_back(e);
    run_txn(32'h1FE0_01E6, 2, 0, 1, 0, -1, -1, -1, 32'hDEAD_BEEF);
    checks++; if (arAddrSeen !== 32'h1FE0_01E4) begin errors++; $display("FAIL unc_araddr: got %h required 1fe001e4", arAddrSeen); end
    checks++; if (arLenSeen !== 8'd0) begin errors++; $display("FAIL unc_arlen: got %0d required 0", arLenSeen); end
    checks++; if (rbaCyc !== acceptCyc + 3) begin errors++; $display("FAIL unc_rba_time: got %0d required %0d", rbaCyc, acceptCyc + 3); end
    checks++; if (rbaCount - c0 !== 1) begin errors++; $display("FAIL unc_pulses: got %0d required 1", rbaCount - c0); end
  endtask

  task automatic test_both_requests;
    push_exp(16, 32'h5500_0000, 1'b0);
    run_txn(32'h0000_2468, 3, 0, 16, 0, -1, -1, -1, 32'h5500_0000);
    checks++; if (arAddrSeen !== 32'h0000_2440 || arLenSeen !== 8'd15) begin errors++; $display("FAIL both_cached_wins: addr=%h len=%0d required 00002440/15", arAddrSeen, arLenSeen); end
  endtask

  task automatic test_backpressure;
    int c0;
    c0 = rbaCount;
    push_exp(16, 32'h3300_0010, 1'b0);
    run_txn(32'h0000_1234, 1, 3, 16, 1, -1, -1, -1, 32'h3300_0010);
    checks++; if (arStable !== 1'b1) begin errors++; $display("FAIL bp_ar_stable: got %b required 1", arStable); end
    checks++; if (arAddrSeen !== 32'h0000_1200) begin errors++; $display("FAIL bp_araddr: got %h required 00001200", arAddrSeen); end
    checks++; if (rbaCount - c0 !== 1) begin errors++; $display("FAIL bp_pulses: got %0d required 1", rbaCount - c0); end
  endtask

  task automatic test_flush;
    int c0;
    c0 = rbaCount;
    run_txn(32'h0000_8000, 1, 0, 16, 0, -1, 5, -1, 32'h7700_0000);
    checks++; if (beatsAccepted !== 16) begin errors++; $display("FAIL flush_beats: got %0d required 16", beatsAccepted); end
    checks++; if (rbaCount - c0 !== 0) begin errors++; $display("FAIL flush_pulses: got %0d required 0", rbaCount - c0); end
    checks++; if (freeCyc !== lastBeatCyc + 2) begin errors++; $display("FAIL flush_free_time: got %0d required %0d", freeCyc, lastBeatCyc + 2); end
  endtask

  task automatic test_errors;
    push_exp(16, 32'h1100_0000, 1'b1);
    run_txn(32'h0000_4000, 1, 0, 16, 0, 7, -1, -1, 32'h1100_0000);
    push_exp(10, 32'h2200_0000, 1'b1);
    run_txn(32'h0000_4040, 1, 0, 10, 0, -1, -1, -1, 32'h2200_0000);
    checks++; if (beatsAccepted !== 10) begin errors++; $display("FAIL early_last_beats: got %0d required 10", beatsAccepted); end
    push_exp(16, 32'h4400_0000, 1'b1);
    run_txn(32'h0000_4080, 1, 0, 17, 0, -1, -1, -1, 32'h4400_0000);
    checks++; if (beatsAccepted !== 17) begin errors++; $display("FAIL extra_beats: got %0d required 17", beatsAccepted); end
  endtask

  task automatic test_reset_mid_burst;
    int c0;
    run_txn(32'h0000_C000, 1, 0, 16, 0, -1, -1, 4, 32'h6600_0000);
    #1;
    checks++; if (ArValid !== 1'b0 || RReady !== 1'b0 || IRshankhand !== 1'b0) begin errors++; $display("FAIL midrst_ctl: arvalid=%b rready=%b hs=%b required 0/0/0", ArValid, RReady, IRshankhand); end
    checks++; if (ReadBackAble !== 1'b0 || ReadErr !== 1'b0 || CacReadfree !== 1'b1) begin errors++; $display("FAIL midrst_flags: rba=%b err=%b free=%b required 0/0/1", ReadBackAble, ReadErr, CacReadfree); end
    checks++; if (ArAddr !== 32'h0 || ArLen !== 8'h0 || ReadBackDate !== 512'h0) begin errors++; $display("FAIL midrst_regs: addr=%h len=%h data_nonzero=%b required 0", ArAddr, ArLen, |ReadBackDate); end
    @(posedge Clk); #1 Rest = 1;
    c0 = rbaCount;
    push_exp(16, 32'h8800_0000, 1'b0);
    run_txn(32'h0000_C004, 1, 0, 16, 0, -1, -1, -1, 32'h8800_0000);
    checks++; if (rbaCount - c0 !== 1) begin errors++; $display("FAIL midrst_recover: pulses=%0d required 1", rbaCount - c0); end
  endtask

  initial begin
    rbaCount = 0;
    test_reset;
    test_cached;
    test_uncached;
    test_both_requests;
    test_backpressure;
    test_flush;
    test_errors;
    test_reset_mid_burst;
    repeat (3) @(posedge Clk);
    checks++;
    if (sbQ.size() != 0) begin errors++; $display("FAIL sb_drain: %0d lines never returned, required 0", sbQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
